mlp_layer_sequencer: RTL and testbench
======================================

// Module: mlp_layer_sequencer
// PURPOSE
//  Drives the shared counter bus that steps a layer of input-layer neurons through their MAC sequence.
//  Samples every neuron_out at the end of the pipeline and narrows each value to the next layer's data width.
//  Presents the result as one valid/ready word, so it is the consumer end of the neuron counter/data_out interface.
// PARAMETERS
//  NUM_NEURONS  4   neurons in the layer (one neuron_out slice each)
//  NEURON_BITS  15  MSB index of neuron data; neuron_out is NEURON_BITS+9 bits, result slice is NEURON_BITS+1 bits
//  COUNTER_END  3   last weight/data index presented to the neurons
//  PIPE_LAT     3   cycles after COUNTER_END until neuron_out is final (register+mult+adder/ReLU)
// PORTS
//  clk                  in   1                        clock, rising edge
//  rstn                 in   1                        asynchronous active-low reset
//  start                in   1                        request one layer evaluation; honoured only in IDLE
//  act_sel              in   1                        activation select, latched on accepted start
//  counter              out  32                       step index broadcast to all neurons
//  activation_function  out  1                        latched act_sel, stable for whole run
//  neuron_out           in   NUM_NEURONS*(NEURON_BITS+9)   neuron n at slice n, signed
//  out_data             out  NUM_NEURONS*(NEURON_BITS+1)   narrowed results, neuron n at slice n
//  out_valid            out  1                        out_data valid; held until accepted
//  out_ready            in   1                        downstream accepts when out_valid&&out_ready
//  busy                 out  1                        state != IDLE
//  done                 out  1                        1-cycle pulse, cycle after the handshake
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE, counter=32'hFFFF_FFFF (idle code), activation_function=0, out_data=0, out_valid=0, done=0.
//  LAST = COUNTER_END+PIPE_LAT. All outputs registered.
//  IDLE: counter=32'hFFFF_FFFF.
//   start=1 -> RUN, counter=0, latch act_sel.
//  RUN: counter increments by 1 every cycle.
//   At the edge where counter==LAST: sample all neuron_out, narrow into out_data, out_valid=1, counter=32'hFFFF_FFFF -> HOLD.
//  HOLD: out_data and out_valid held stable.
//   out_valid&&out_ready -> IDLE, out_valid=0, done=1 for one cycle.
//  Latency: start sampled at edge E0 -> counter 0..LAST after E0..E(LAST) -> out_valid high after E(LAST+1) (edge 7 for defaults).
//  Ignored inputs: start in RUN or HOLD, including start on the same cycle as the handshake. Earliest restart is the first cycle in IDLE.
//  out_ready outside HOLD: no effect.
//  act_sel changes after acceptance: no effect until the next run.
//  Narrowing: each slice maps signed NEURON_BITS+9 bits to signed NEURON_BITS+1 bits (see CONFIGURATION).
//  Reset mid-run or mid-HOLD: immediately returns to the reset values above; partial results are discarded and no done pulse is produced.
//  counter never wraps: maximum value is LAST.
// CONFIGURATION
//  MLP_SEQ_SATURATE_EN defined: each slice is clamped to [-2^NEURON_BITS, 2^NEURON_BITS-1].
//  MLP_SEQ_SATURATE_EN undefined: each slice is truncated to its low NEURON_BITS+1 bits (wraps).
//  Timing and handshake are identical with and without the macro.
// TESTING (NUM_NEURONS=4, NEURON_BITS=15, COUNTER_END=3, PIPE_LAT=3)
//  1 Reset -> counter=FFFF_FFFF, out_valid=0, busy=0. start pulse with act_sel=1 -> counter 0,1,..,6 on consecutive cycles; activation_function=1; out_valid rises 8 cycles after start.
//  2 neuron_out slices {24'sh000010,24'sh7FFF,24'shFFFFFF,0}, out_ready=1 -> out_data {16'h0010,16'h7FFF,16'hFFFF,0}; done pulses 1 cycle after valid.
//  3 out_ready=0 for 5 cycles in HOLD, neuron_out changing -> out_data unchanged, out_valid=1 throughout; start pulses ignored; then out_ready=1 -> single done.
//  4 slice0=24'sh012345, slice1=24'shFF0000: with MLP_SEQ_SATURATE_EN -> 16'h7FFF, 16'h8000; without -> 16'h2345, 16'h0000.
//  5 rstn low while counter==4 -> counter=FFFF_FFFF and busy=0 immediately (async); no done; new start after release runs a full sequence from 0.
//  6 start high continuously, out_ready=1 -> runs back-to-back; each run has exactly one IDLE cycle between done and the next counter=0.

Source files
------------

// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: steps a neuron layer through its MAC sequence and hands the narrowed results downstream
//   clk, rstn (async active-low) | start, act_sel in | counter, activation_function out (neuron bus)
//   neuron_out in (NUM_NEURONS signed slices) | out_data, out_valid out, out_ready in | busy, done out
//   MLP_SEQ_SATURATE_EN: clamp each slice instead of truncating it
module mlp_layer_sequencer #(
  parameter int NUM_NEURONS = 4,
  parameter int NEURON_BITS = 15,
  parameter int COUNTER_END = 3,
  parameter int PIPE_LAT    = 3
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  start,
  input  logic                                  act_sel,
  output logic [31:0]                           counter,
  output logic                                  activation_function,
  input  logic [NUM_NEURONS*(NEURON_BITS+9)-1:0] neuron_out,
  output logic [NUM_NEURONS*(NEURON_BITS+1)-1:0] out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  busy,
  output logic                                  done
);
  localparam int NW = NEURON_BITS + 9;
  localparam int OW = NEURON_BITS + 1;
  localparam logic [31:0] LAST = 32'(COUNTER_END + PIPE_LAT);
  localparam logic [31:0] IDLE_CODE = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state_q, state_d;
  logic [31:0] counter_q, counter_d;
  logic act_q, act_d, valid_q, valid_d, done_q, done_d;
  logic [NUM_NEURONS*OW-1:0] data_q, data_d, narrowed;
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_narrow
    logic [NW-1:0] s;
    assign s = neuron_out[n*NW +: NW];
`ifdef MLP_SEQ_SATURATE_EN
    // in range only when every bit above the result sign matches it
    assign narrowed[n*OW +: OW] = (&s[NW-1:OW-1] || ~|s[NW-1:OW-1]) ? s[OW-1:0]
                                  : {s[NW-1], {(OW-1){~s[NW-1]}}};
`else
    assign narrowed[n*OW +: OW] = s[OW-1:0];
`endif
  end
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    act_d     = act_q;
    data_d    = data_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d   = RUN;
        counter_d = '0;
        act_d     = act_sel;
      end
      RUN: if (counter_q == LAST) begin
        state_d   = HOLD;
        counter_d = IDLE_CODE;
        data_d    = narrowed;
        valid_d   = 1'b1;
      end else begin
        counter_d = counter_q + 32'd1;
      end
      HOLD: if (out_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d   = IDLE;
        counter_d = IDLE_CODE;
        valid_d   = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      counter_q <= IDLE_CODE;
      act_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      act_q     <= act_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end
  assign counter             = counter_q;
  assign activation_function = act_q;
  assign out_data            = data_q;
  assign out_valid           = valid_q;
  assign done                = done_q;
  assign busy                = state_q != IDLE;
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// tb_mlp_layer_sequencer: table, corner-case and random checks of mlp_layer_sequencer
module tb_mlp_layer_sequencer;
  localparam int LAST = 6;
  logic clk, rstn, start, act_sel, out_valid, out_ready, busy, done, activation_function;
  logic [31:0] counter;
  logic [95:0] neuron_out;
  logic [63:0] out_data;
  int total = 0, bad = 0;
  mlp_layer_sequencer #(.NUM_NEURONS(4), .NEURON_BITS(15), .COUNTER_END(3), .PIPE_LAT(3)) dut (
    .clk(clk), .rstn(rstn), .start(start), .act_sel(act_sel), .counter(counter),
    .activation_function(activation_function), .neuron_out(neuron_out), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  typedef struct {logic [23:0] nin; logic [15:0] wrap; logic [15:0] sat;} vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] narrow1(input logic [23:0] x);
    int v;
    v = int'($signed(x));
`ifdef MLP_SEQ_SATURATE_EN
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`endif
    return v[15:0];
  endfunction
  function automatic logic [63:0] model(input logic [95:0] nin);
    logic [63:0] r;
    for (int n = 0; n < 4; n++) r[n*16 +: 16] = narrow1(nin[n*24 +: 24]);
    return r;
  endfunction
  task automatic do_run(input logic [95:0] nin, input logic a, input int stall, output logic [63:0] dout);
    neuron_out = nin;
    act_sel = a;
    start = 1;
    out_ready = 0;
    @(posedge clk); #1;
    start = 0;
    act_sel = ~a;
    for (int k = 0; k <= LAST; k++) begin
      chk("run_counter", counter, 64'(k));
      chk("run_valid", out_valid, 0);
      chk("run_busy", busy, 1);
      chk("run_act", activation_function, a);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    out_ready = 0;
    chk("hold_valid", out_valid, 1);
    chk("hold_counter", counter, 64'hFFFF_FFFF);
    chk("hold_act", activation_function, a);
    dout = out_data;
    for (int i = 0; i < stall; i++) begin
      neuron_out = {$urandom, $urandom, $urandom};
      start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, dout);
      chk("stall_done", done, 0);
      chk("stall_counter", counter, 64'hFFFF_FFFF);
    end
    start = 1;
    out_ready = 1;
    @(posedge clk); #1;
    start = 0;
    out_ready = 0;
    chk("hs_done", done, 1);
    chk("hs_valid", out_valid, 0);
    chk("hs_busy", busy, 0);
    @(posedge clk); #1;
    chk("post_done", done, 0);
    chk("post_counter", counter, 64'hFFFF_FFFF);
    chk("post_busy", busy, 0);
  endtask
  initial begin
    logic [95:0] nin;
    logic [63:0] got, exp;
    tbl[0] = '{24'h000000, 16'h0000, 16'h0000};
    tbl[1] = '{24'hFFFFFF, 16'hFFFF, 16'hFFFF};
    tbl[2] = '{24'h007FFF, 16'h7FFF, 16'h7FFF};
    tbl[3] = '{24'h000010, 16'h0010, 16'h0010};
    tbl[4] = '{24'h012345, 16'h2345, 16'h7FFF};
    tbl[5] = '{24'hFF0000, 16'h0000, 16'h8000};
    tbl[6] = '{24'h008000, 16'h8000, 16'h7FFF};
    tbl[7] = '{24'hFF7FFF, 16'h7FFF, 16'h8000};
    rstn = 0; start = 0; act_sel = 0; out_ready = 0; neuron_out = '0;
    #12;
    chk("rst_counter", counter, 64'hFFFF_FFFF);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_act", activation_function, 0);
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 4; n++) begin
`ifdef MLP_SEQ_SATURATE_EN
        exp[n*16 +: 16] = tbl[r*4+n].sat;
`else
        exp[n*16 +: 16] = tbl[r*4+n].wrap;
`endif
        nin[n*24 +: 24] = tbl[r*4+n].nin;
      end
      do_run(nin, r == 0, 0, got);
      for (int n = 0; n < 4; n++) chk($sformatf("tbl_slice%0d", r*4+n), got[n*16 +: 16], exp[n*16 +: 16]);
    end
    nin = {24'h000100, 24'hFFF000, 24'h012345, 24'hFF0000};
    do_run(nin, 1, 5, got);
    chk("stall_result", got, model(nin));
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_counter", counter, 4);
    #2 rstn = 0;
    #1;
    chk("arst_counter", counter, 64'hFFFF_FFFF);
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    @(posedge clk); #1;
    rstn = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("arst_nodone", done, 0);
      chk("arst_idle", busy, 0);
    end
    nin = {$urandom, $urandom, $urandom};
    do_run(nin, 0, 1, got);
    chk("arst_rerun", got, model(nin));
    start = 1;
    out_ready = 1;
    @(posedge clk); #1;
    for (int t = 0; t < 27; t++) begin
      int p;
      p = t % 9;
      chk("b2b_counter", counter, p <= LAST ? 64'(p) : 64'hFFFF_FFFF);
      chk("b2b_valid", out_valid, p == 7);
      chk("b2b_done", done, p == 8);
      @(posedge clk); #1;
    end
    start = 0;
    repeat (10) @(posedge clk);
    #1;
    out_ready = 0;
    chk("b2b_end_busy", busy, 0);
    for (int r = 0; r < 8; r++) begin
      for (int n = 0; n < 4; n++) begin
        logic [31:0] x;
        x = $urandom;
        nin[n*24 +: 24] = $urandom_range(0, 1) ? {{8{x[15]}}, x[15:0]} : x[23:0];
      end
      do_run(nin, 1'($urandom_range(0, 1)), $urandom_range(0, 3), got);
      chk("rand_result", got, model(nin));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
